note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 5, giving the note lanes per chart step (one bit per fret button).
REQ-002 SHALL have parameter DEPTH, default 256, giving the maximum chart steps stored; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level-sampled request to begin playback from step 0.
REQ-006 SHALL have port pause, input, 1, level hold of playback.
REQ-007 SHALL have port loop_en, input, 1, which wraps to step 0 at chart end instead of finishing.
REQ-008 SHALL have port tick, input, 1, a one-cycle beat strobe that advances one step.
REQ-009 SHALL have port song_len, input, AW+1, the number of valid chart steps.
REQ-010 SHALL have ports wr_en (input, 1), wr_addr (input, AW) and wr_data (input, LANES) forming the chart load port.
REQ-011 SHALL have port notes, output, LANES, the current chart step.
REQ-012 SHALL have port note_valid, output, 1, a one-cycle pulse when notes is updated.
REQ-013 SHALL have port pos, output, AW, the index of the next step to emit.
REQ-014 SHALL have ports busy (output, 1), high in PLAY or PAUSED, and done (output, 1), a one-cycle end-of-chart pulse.

Function
REQ-015 SHALL store the chart in a DEPTH x LANES array; wr_en SHALL write wr_data to wr_addr on the clock edge only in IDLE or DONE, and SHALL be ignored in PLAY or PAUSED.
REQ-016 SHALL implement states IDLE, PLAY, PAUSED and DONE.
REQ-017 SHALL define effective length L = min(song_len, DEPTH).
REQ-018 SHALL, on start in IDLE or DONE with L>0: enter PLAY, set pos=0 and clear notes to 0.
REQ-019 SHALL, on start with L=0: enter DONE and pulse done the next cycle, with no note output.
REQ-020 SHALL, on start in PLAY or PAUSED: restart at pos=0 in PLAY, clear notes, and drop any same-cycle tick.
REQ-021 SHALL, on tick in PLAY with no start and pause low at edge N: set notes=mem[pos] and note_valid=1 at N+1, giving 1-cycle latency.
REQ-022 SHALL, on the tick of REQ-021, set pos to pos+1 if pos < L-1.
REQ-023 SHALL, on the tick of REQ-021 when pos = L-1 and loop_en=1: set pos to 0 and stay in PLAY with no done pulse.
REQ-024 SHALL, on the tick of REQ-021 when pos = L-1 and loop_en=0: enter DONE and assert done in the same cycle as that final note_valid.
REQ-025 SHALL sample loop_en at the final-step tick only.
REQ-026 SHALL hold notes between emissions; note_valid and done SHALL be low otherwise.
REQ-027 SHALL, in PLAY with pause=1, enter PAUSED; a same-cycle tick SHALL be dropped and pos held.
REQ-028 SHALL, in PAUSED, ignore ticks; pause=0 SHALL return to PLAY on the next edge, and start SHALL restart per REQ-020.
REQ-029 SHALL, in DONE, hold the last notes and pos until start; ticks SHALL be ignored.
REQ-030 SHALL ignore ticks in IDLE.
REQ-031 SHALL take song_len changes during PLAY effect at the next tick comparison.
REQ-032 SHALL, if pos >= L at a tick, treat that tick as the final-step tick of REQ-023/REQ-024.

Reset
REQ-033 SHALL, on reset asserted at any time including mid-playback, immediately force state IDLE, notes=0, note_valid=0, pos=0, busy=0 and done=0.
REQ-034 SHALL NOT clear or alter the chart memory contents on reset.
REQ-035 SHALL, after reset deasserts, require start before any note output.

Verification
REQ-036 SHALL cover: load steps 0..3 = 00001, 00100, 10000, 01000; song_len=4, loop_en=0; start; then 4 ticks -> notes follow that sequence one cycle after each tick, note_valid pulsed 4 times, and done coincides with 01000, then state DONE.
REQ-037 SHALL cover: the same chart with loop_en=1 and 6 ticks -> 00001, 00100, 10000, 01000, 00001, 00100, no done pulse, and pos=2.
REQ-038 SHALL cover: pause=1 with a same-cycle tick after step 1 -> no note_valid and pos held at 2; 3 ticks while paused are ignored; pause=0 then a tick -> notes=10000.
REQ-039 SHALL cover: wr_en during PLAY to address 0 -> memory unchanged; after DONE, a restart emits the original 00001 first.
REQ-040 SHALL cover: song_len=0 and start -> done pulse, no note_valid, state DONE; and song_len=300 with DEPTH=256 -> done on the tick at pos=255.
REQ-041 SHALL cover: reset asserted mid-PLAY at pos=2 -> all outputs zero asynchronously; after release, ticks produce nothing until start; memory contents are retained.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: rhythm-game chart player; emits one stored lane pattern per beat tick.
// Supports pause, loop-at-end and chart (re)loading while stopped.
module note_sequencer #(
    parameter int LANES = 5,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             loop_en,
    input  logic             tick,
    input  logic [AW:0]      song_len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_data,
    output logic [LANES-1:0] notes,
    output logic             note_valid,
    output logic [AW-1:0]    pos,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, PLAY, PAUSED, DONE} state_t;

    state_t           state_q;
    logic [AW-1:0]    pos_q;
    logic [LANES-1:0] notes_q;
    logic             note_valid_q;
    logic             done_q;
    logic [LANES-1:0] mem [DEPTH];
    logic [AW:0]      len_eff;
    logic             last_step;

    assign len_eff   = (song_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : song_len;
    // A shrunken song_len that leaves pos beyond the end also counts as the final step.
    assign last_step = ({1'b0, pos_q} + (AW+1)'(1)) >= len_eff;

    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE || state_q == DONE))
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            notes_q      <= '0;
            note_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            note_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (start) begin
                if (len_eff == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= PLAY;
                    pos_q   <= '0;
                    notes_q <= '0;
                end
            end else begin
                case (state_q)
                    PLAY: begin
                        if (pause) begin
                            state_q <= PAUSED;
                        end else if (tick) begin
                            notes_q      <= mem[pos_q];
                            note_valid_q <= 1'b1;
                            if (!last_step) begin
                                pos_q <= pos_q + 1'b1;
                            end else if (loop_en) begin
                                pos_q <= '0;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    PAUSED: if (!pause) state_q <= PLAY;
                    default: ;
                endcase
            end
        end
    end

    assign notes      = notes_q;
    assign note_valid = note_valid_q;
    assign pos        = pos_q;
    assign done       = done_q;
    assign busy       = (state_q == PLAY) || (state_q == PAUSED);
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_note_sequencer;
    localparam int LANES = 5;
    localparam int DEPTH = 256;
    localparam int AW = 8;

    logic             clk = 0;
    logic             reset = 1;
    logic             start = 0, pause = 0, loop_en = 0, tick = 0, wr_en = 0;
    logic [AW:0]      song_len = 0;
    logic [AW-1:0]    wr_addr = 0;
    logic [LANES-1:0] wr_data = 0;
    logic [LANES-1:0] notes;
    logic             note_valid, busy, done;
    logic [AW-1:0]    pos;

    typedef struct {
        logic             nv;
        logic             dn;
        logic [LANES-1:0] nt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    note_sequencer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .loop_en(loop_en),
        .tick(tick), .song_len(song_len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .notes(notes), .note_valid(note_valid), .pos(pos),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_valid || done) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL out: unexpected nv=%0b done=%0b notes=%b", note_valid, done, notes);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (note_valid !== e.nv || done !== e.dn || (e.nv && notes !== e.nt)) begin
                    fails++;
                    $display("FAIL out: got nv=%0b done=%0b notes=%b, want nv=%0b done=%0b notes=%b",
                             note_valid, done, notes, e.nv, e.dn, e.nt);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1;
        step();
        tick = 0;
        step();
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1;
        wr_addr = AW'(a);
        wr_data = LANES'(d);
        step();
        wr_en = 0;
    endtask

    task automatic push(input logic [LANES-1:0] n, input logic d);
        q.push_back('{nv: 1'b1, dn: d, nt: n});
    endtask

    function automatic logic [LANES-1:0] chart(input int i);
        logic [LANES-1:0] base [4];
        base = '{5'b00001, 5'b00100, 5'b10000, 5'b01000};
        return (i < 4) ? base[i] : LANES'((i % 31) + 1);
    endfunction

    initial begin
        step();
        step();
        chk("rst_notes", int'(notes), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_nv_done", int'({note_valid, done}), 0);
        reset = 0;
        step();

        // basic 4-step chart, play to end
        for (int i = 0; i < 4; i++) wr(i, int'(chart(i)));
        song_len = 4;
        loop_en = 0;
        do_start();
        chk("start_busy", int'(busy), 1);
        chk("start_pos", int'(pos), 0);
        for (int i = 0; i < 4; i++) begin
            push(chart(i), i == 3);
            do_tick();
        end
        chk("end_busy", int'(busy), 0);
        chk("end_pos", int'(pos), 3);
        chk("end_notes", int'(notes), 8);
        do_tick();

        // looping playback
        loop_en = 1;
        do_start();
        for (int i = 0; i < 6; i++) begin
            push(chart(i % 4), 1'b0);
            do_tick();
        end
        chk("loop_pos", int'(pos), 2);
        chk("loop_busy", int'(busy), 1);

        // restart from PLAY, then pause
        loop_en = 0;
        do_start();
        chk("restart_notes", int'(notes), 0);
        chk("restart_pos", int'(pos), 0);
        push(chart(0), 1'b0); do_tick();
        push(chart(1), 1'b0); do_tick();
        pause = 1;
        tick = 1;
        step();
        tick = 0;
        chk("pause_pos", int'(pos), 2);
        chk("pause_busy", int'(busy), 1);
        repeat (3) do_tick();
        chk("paused_pos", int'(pos), 2);
        pause = 0;
        step();
        push(chart(2), 1'b0); do_tick();
        chk("resume_notes", int'(notes), 16);
        push(chart(3), 1'b1); do_tick();
        chk("pause_done_busy", int'(busy), 0);

        // write during PLAY must be ignored
        do_start();
        wr(0, 31);
        for (int i = 0; i < 4; i++) begin
            push(chart(i), i == 3);
            do_tick();
        end
        do_start();
        for (int i = 0; i < 4; i++) begin
            push(chart(i), i == 3);
            do_tick();
        end

        // song_len shrinks mid-play below pos
        do_start();
        push(chart(0), 1'b0); do_tick();
        push(chart(1), 1'b0); do_tick();
        song_len = 2;
        push(chart(2), 1'b1); do_tick();
        chk("shrink_busy", int'(busy), 0);
        chk("shrink_pos", int'(pos), 2);

        // zero length
        song_len = 0;
        q.push_back('{nv: 1'b0, dn: 1'b1, nt: '0});
        do_start();
        step();
        chk("zero_busy", int'(busy), 0);

        // song_len beyond DEPTH clamps to 256
        for (int i = 4; i < DEPTH; i++) wr(i, int'(chart(i)));
        song_len = 300;
        do_start();
        for (int i = 0; i < DEPTH; i++) push(chart(i), i == DEPTH - 1);
        tick = 1;
        repeat (DEPTH) step();
        tick = 0;
        step();
        chk("clamp_pos", int'(pos), 255);
        chk("clamp_busy", int'(busy), 0);

        // asynchronous reset mid-play
        song_len = 4;
        do_start();
        push(chart(0), 1'b0); do_tick();
        push(chart(1), 1'b0); do_tick();
        chk("pre_rst_pos", int'(pos), 2);
        #3 reset = 1;
        #1;
        chk("arst_notes", int'(notes), 0);
        chk("arst_pos", int'(pos), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_nv_done", int'({note_valid, done}), 0);
        step();
        reset = 0;
        repeat (3) do_tick();
        chk("post_rst_pos", int'(pos), 0);
        chk("post_rst_busy", int'(busy), 0);
        do_start();
        for (int i = 0; i < 4; i++) begin
            push(chart(i), i == 3);
            do_tick();
        end

        step();
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
